// File: rtl/cnn_line_buffer.sv
// cnn_line_buffer
//   K-row line buffer that converts a raster-ordered pixel stream into K
//   vertically aligned pixels per column. This is the column feed for a KxK
//   convolution window. Row storage is K circularly rotated memories, so row
//   data is never copied between memories. The write row pointer advances
//   instead, and the output lanes are re-mapped to match.
//
//   Optional feature macro: CNN_LINE_BUF_ZERO_PAD_EN
//     When defined, every accepted pixel emits a column from row 0 onward.
//     Lanes that would refer to rows above the image are forced to zero,
//     which gives K-1 rows of top zero-padding.
//
// Ports
//   i_clock    : clock
//   i_reset    : asynchronous, active-low reset
//   i_clear    : synchronous flush of pointers, fill state and o_valid
//   i_valid    : input pixel valid
//   o_ready    : input handshake; a pixel is accepted on i_valid && o_ready
//   i_data     : input pixel, raster order
//   o_valid    : output column valid
//   i_ready    : downstream ready; a column is taken on o_valid && i_ready
//   o_data     : K column pixels; lane 0 is the oldest row, lane K-1 the newest
//   o_col      : column index of o_data
//   o_last_col : o_col is the last column of the row
module cnn_line_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int IMG_WIDTH   = 224,
  parameter int KERNEL_ROWS = 3,
  parameter int COL_W       = $clog2(IMG_WIDTH)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data [0:KERNEL_ROWS-1],
  output logic [COL_W-1:0]      o_col,
  output logic                  o_last_col
);

  localparam int ROW_W = $clog2(KERNEL_ROWS);

  logic [ROW_W-1:0]       wr_row_reg;
  logic [COL_W-1:0]       wr_col_reg;
  logic [ROW_W-1:0]       rows_filled_reg;
  logic                   o_valid_reg;
  logic [ROW_W-1:0]       rot_reg;        // wr_row captured at emit time
  logic [COL_W-1:0]       col_reg;
  logic [DATA_WIDTH-1:0]  newest_reg;     // lane K-1, taken straight from i_data
  logic                   loaded_reg;     // at least one column emitted since reset
  logic [KERNEL_ROWS-2:0] mask_reg;       // lanes forced to zero for the held column
  logic [KERNEL_ROWS-2:0] mask_next;
  logic [DATA_WIDTH-1:0]  rd_data [0:KERNEL_ROWS-1];

  logic accept;
  logic emit;
  logic last_col_in;

  // The output register is single entry, so we can take a new pixel only when
  // it is empty or being drained this cycle. A flush blocks input.
  assign o_ready     = !i_clear && (!o_valid_reg || i_ready);
  assign accept      = i_valid && o_ready;
  assign last_col_in = (wr_col_reg == COL_W'(IMG_WIDTH - 1));

`ifdef CNN_LINE_BUF_ZERO_PAD_EN
  assign emit = accept;

  // Lane j covers row (current - (K-1) + j). That row lies above the image
  // while fewer than (K-1) - j rows have been completed.
  genvar gi;
  generate
    for (gi = 0; gi < KERNEL_ROWS - 1; gi++) begin : g_mask
      assign mask_next[gi] = (int'(rows_filled_reg) + gi) < (KERNEL_ROWS - 1);
    end
  endgenerate
`else
  assign emit      = accept && (rows_filled_reg == ROW_W'(KERNEL_ROWS - 1));
  assign mask_next = '0;
  genvar gi;
`endif

  // Row memories. Each memory has a registered read port that loads only on
  // emit, so the held column stays stable under backpressure. The row being
  // written is also read (read-first), but that value is never routed to a
  // lane because lane K-1 comes from i_data instead.
  generate
    for (gi = 0; gi < KERNEL_ROWS; gi++) begin : g_row
      logic [DATA_WIDTH-1:0] mem [0:IMG_WIDTH-1];
      logic [DATA_WIDTH-1:0] rd_reg;

      always_ff @(posedge i_clock) begin
        if (accept && (wr_row_reg == ROW_W'(gi)))
          mem[wr_col_reg] <= i_data;
        if (emit)
          rd_reg <= mem[wr_col_reg];
      end

      assign rd_data[gi] = rd_reg;
    end
  endgenerate

  // Write pointers, fill state and output register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_row_reg      <= '0;
      wr_col_reg      <= '0;
      rows_filled_reg <= '0;
      o_valid_reg     <= 1'b0;
      rot_reg         <= '0;
      col_reg         <= '0;
      newest_reg      <= '0;
      loaded_reg      <= 1'b0;
      mask_reg        <= '0;
    end else if (i_clear) begin
      wr_row_reg      <= '0;
      wr_col_reg      <= '0;
      rows_filled_reg <= '0;
      o_valid_reg     <= 1'b0;
    end else begin
      if (accept) begin
        if (last_col_in) begin
          wr_col_reg <= '0;
          if (wr_row_reg == ROW_W'(KERNEL_ROWS - 1))
            wr_row_reg <= '0;
          else
            wr_row_reg <= wr_row_reg + ROW_W'(1);
          if (rows_filled_reg != ROW_W'(KERNEL_ROWS - 1))
            rows_filled_reg <= rows_filled_reg + ROW_W'(1);
        end else begin
          wr_col_reg <= wr_col_reg + COL_W'(1);
        end
      end

      if (emit) begin
        o_valid_reg <= 1'b1;
        rot_reg     <= wr_row_reg;
        col_reg     <= wr_col_reg;
        newest_reg  <= i_data;
        loaded_reg  <= 1'b1;
        mask_reg    <= mask_next;
      end else if (o_valid_reg && i_ready) begin
        o_valid_reg <= 1'b0;
      end
    end
  end

  // Lane j < K-1 reads memory (rot + 1 + j) mod K. The sum never exceeds
  // 2K-2, so one conditional subtract is enough for the modulo.
  generate
    for (gi = 0; gi < KERNEL_ROWS - 1; gi++) begin : g_lane
      logic [ROW_W:0]   sel_sum;
      logic [ROW_W-1:0] sel;

      assign sel_sum = {1'b0, rot_reg} + (ROW_W + 1)'(gi + 1);
      assign sel = (sel_sum >= (ROW_W + 1)'(KERNEL_ROWS))
                   ? ROW_W'(sel_sum - (ROW_W + 1)'(KERNEL_ROWS))
                   : sel_sum[ROW_W-1:0];
      // The read registers are not reset, so gate them until the first emit
      // to keep o_data at zero out of reset.
      assign o_data[gi] = (loaded_reg && !mask_reg[gi]) ? rd_data[sel] : '0;
    end
  endgenerate

  assign o_data[KERNEL_ROWS-1] = newest_reg;
  assign o_valid               = o_valid_reg;
  assign o_col                 = col_reg;
  assign o_last_col            = (col_reg == COL_W'(IMG_WIDTH - 1));

endmodule
